// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage: ALU op codes, R-type funct
// values, multiplier FSM states and the EX/MEM control bundle.
package ex_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_ORI   = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_BUSY = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_t;

    typedef struct packed {
        logic reg_w;
        logic mem_w;
        logic mem_r;
        logic mem_to_reg;
    } exmem_ctrl_t;

endpackage

// File: rtl/ex_mult.sv
// Iterative 32-step shift-add multiplier (low 32 bits of the product).
// Only built when EX_MULT_EN is defined.
`ifdef EX_MULT_EN
module ex_mult
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    mult_state_t state_reg, state_next;
    logic [4:0]  count_reg;
    logic [31:0] a_reg, b_reg, acc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MULT_IDLE: if (start) state_next = MULT_BUSY;
            MULT_BUSY: if (count_reg == 5'd31) state_next = MULT_DONE;
            MULT_DONE: state_next = MULT_IDLE;
            default:   state_next = MULT_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= MULT_IDLE;
            count_reg <= 5'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            acc_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == MULT_IDLE && start) begin
                a_reg     <= a_in;
                b_reg     <= b_in;
                acc_reg   <= 32'd0;
                count_reg <= 5'd0;
            end else if (state_reg == MULT_BUSY) begin
                if (b_reg[0]) acc_reg <= acc_reg + a_reg;
                a_reg     <= a_reg << 1;
                b_reg     <= b_reg >> 1;
                count_reg <= count_reg + 5'd1;
            end
        end
    end

    assign busy    = (state_reg == MULT_BUSY);
    assign done    = (state_reg == MULT_DONE);
    assign product = acc_reg;

endmodule
`endif

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, destination select and the
// EX/MEM register (falling-edge). EX_MULT_EN adds an iterative multiplier.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Rs_data_in,
    input  logic [31:0] Rt_data_in,
    input  logic [31:0] Imm_in,
    input  logic [1:0]  ALU_op_in,
    input  logic [4:0]  Rs_addr_in,
    input  logic [4:0]  Rt_addr_in,
    input  logic [4:0]  Rd_addr_in,
    input  logic        ALU_src_in,
    input  logic        Reg_dst_in,
    input  logic        Reg_w_in,
    input  logic        Mem_w_in,
    input  logic        Mem_r_in,
    input  logic        Mem_to_reg_in,
    input  logic        MEMWB_Reg_w_in,
    input  logic [4:0]  MEMWB_Rd_addr_in,
    input  logic [31:0] MEMWB_data_in,
    output logic [31:0] ALU_result_out,
    output logic [31:0] Rt_data_out,
    output logic [4:0]  Rd_addr_out,
    output logic        Zero_out,
    output logic        Reg_w_out,
    output logic        Mem_w_out,
    output logic        Mem_r_out,
    output logic        Mem_to_reg_out,
    output logic        Stall_out
);

    exmem_ctrl_t      ctrl_reg, ctrl_next;
    logic [1:0][31:0] rf_data, fwd_data;
    logic [1:0][4:0]  src_addr;
    logic [31:0]      op_a, op_b, alu_result, result_next;
    logic [5:0]       funct;
    logic             bubble;

    // Index 0 is Rs, index 1 is Rt.
    assign rf_data  = {Rt_data_in, Rs_data_in};
    assign src_addr = {Rt_addr_in, Rs_addr_in};

    // EX/MEM (the immediately preceding instruction) has priority over MEM/WB.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic exmem_hit, memwb_hit;
        assign exmem_hit = ctrl_reg.reg_w && (Rd_addr_out != 5'd0)
                           && (Rd_addr_out == src_addr[gi]);
        assign memwb_hit = MEMWB_Reg_w_in && (MEMWB_Rd_addr_in != 5'd0)
                           && (MEMWB_Rd_addr_in == src_addr[gi]);
        assign fwd_data[gi] = exmem_hit ? ALU_result_out :
                              memwb_hit ? MEMWB_data_in  : rf_data[gi];
    end

    assign op_a  = fwd_data[0];
    assign funct = Imm_in[5:0];

    always_comb begin
        op_b = fwd_data[1];
        if (ALU_src_in)
            op_b = (ALU_op_in == ALU_OP_ORI) ? {16'd0, Imm_in[15:0]} : Imm_in;
    end

    always_comb begin
        alu_result = 32'd0;
        case (ALU_op_in)
            ALU_OP_ADD: alu_result = op_a + op_b;
            ALU_OP_SUB: alu_result = op_a - op_b;
            ALU_OP_ORI: alu_result = op_a | op_b;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_result = op_a + op_b;
                    FUNCT_SUB: alu_result = op_a - op_b;
                    FUNCT_AND: alu_result = op_a & op_b;
                    FUNCT_OR:  alu_result = op_a | op_b;
                    FUNCT_SLT: alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
                    default:   alu_result = 32'd0;
                endcase
            end
        endcase
    end

`ifdef EX_MULT_EN
    logic        is_mult, mult_busy, mult_done;
    logic [31:0] mult_product;

    assign is_mult = (ALU_op_in == ALU_OP_RTYPE) && (funct == FUNCT_MULT);

    ex_mult u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (is_mult),
        .a_in    (op_a),
        .b_in    (op_b),
        .busy    (mult_busy),
        .done    (mult_done),
        .product (mult_product)
    );

    // The product is registered on the same edge that ID/EX advances.
    assign Stall_out   = is_mult && !mult_done;
    assign bubble      = Stall_out || mult_busy;
    assign result_next = is_mult ? mult_product : alu_result;
`else
    assign Stall_out   = 1'b0;
    assign bubble      = 1'b0;
    assign result_next = alu_result;
`endif

    assign ctrl_next = '{reg_w: Reg_w_in, mem_w: Mem_w_in,
                         mem_r: Mem_r_in, mem_to_reg: Mem_to_reg_in};

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ALU_result_out <= 32'd0;
            Rt_data_out    <= 32'd0;
            Rd_addr_out    <= 5'd0;
            Zero_out       <= 1'b0;
            ctrl_reg       <= '0;
        end else if (bubble) begin
            ALU_result_out <= 32'd0;
            Rt_data_out    <= 32'd0;
            Rd_addr_out    <= 5'd0;
            Zero_out       <= 1'b0;
            ctrl_reg       <= '0;
        end else begin
            ALU_result_out <= result_next;
            Rt_data_out    <= fwd_data[1];
            Rd_addr_out    <= Reg_dst_in ? Rd_addr_in : Rt_addr_in;
            Zero_out       <= (result_next == 32'd0);
            ctrl_reg       <= ctrl_next;
        end
    end

    assign Reg_w_out      = ctrl_reg.reg_w;
    assign Mem_w_out      = ctrl_reg.mem_w;
    assign Mem_r_out      = ctrl_reg.mem_r;
    assign Mem_to_reg_out = ctrl_reg.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; multiplier steps run only when
// EX_MULT_EN is defined.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Rs_data_in, Rt_data_in, Imm_in, MEMWB_data_in;
    logic [1:0]  ALU_op_in;
    logic [4:0]  Rs_addr_in, Rt_addr_in, Rd_addr_in, MEMWB_Rd_addr_in;
    logic        ALU_src_in, Reg_dst_in, Reg_w_in, Mem_w_in, Mem_r_in, Mem_to_reg_in;
    logic        MEMWB_Reg_w_in;
    logic [31:0] ALU_result_out, Rt_data_out;
    logic [4:0]  Rd_addr_out;
    logic        Zero_out, Reg_w_out, Mem_w_out, Mem_r_out, Mem_to_reg_out, Stall_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .Rs_data_in       (Rs_data_in),
        .Rt_data_in       (Rt_data_in),
        .Imm_in           (Imm_in),
        .ALU_op_in        (ALU_op_in),
        .Rs_addr_in       (Rs_addr_in),
        .Rt_addr_in       (Rt_addr_in),
        .Rd_addr_in       (Rd_addr_in),
        .ALU_src_in       (ALU_src_in),
        .Reg_dst_in       (Reg_dst_in),
        .Reg_w_in         (Reg_w_in),
        .Mem_w_in         (Mem_w_in),
        .Mem_r_in         (Mem_r_in),
        .Mem_to_reg_in    (Mem_to_reg_in),
        .MEMWB_Reg_w_in   (MEMWB_Reg_w_in),
        .MEMWB_Rd_addr_in (MEMWB_Rd_addr_in),
        .MEMWB_data_in    (MEMWB_data_in),
        .ALU_result_out   (ALU_result_out),
        .Rt_data_out      (Rt_data_out),
        .Rd_addr_out      (Rd_addr_out),
        .Zero_out         (Zero_out),
        .Reg_w_out        (Reg_w_out),
        .Mem_w_out        (Mem_w_out),
        .Mem_r_out        (Mem_r_out),
        .Mem_to_reg_out   (Mem_to_reg_out),
        .Stall_out        (Stall_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        Rs_data_in = '0; Rt_data_in = '0; Imm_in = '0; ALU_op_in = '0;
        Rs_addr_in = '0; Rt_addr_in = '0; Rd_addr_in = '0;
        ALU_src_in = 0; Reg_dst_in = 0; Reg_w_in = 0; Mem_w_in = 0;
        Mem_r_in = 0; Mem_to_reg_in = 0;
        MEMWB_Reg_w_in = 0; MEMWB_Rd_addr_in = '0; MEMWB_data_in = '0;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [4:0] rs_a, input logic [31:0] rs_d,
                         input logic [4:0] rt_a, input logic [31:0] rt_d, input logic [4:0] rd_a);
        clear_in();
        ALU_op_in = 2'b10; Imm_in = {26'd0, fn};
        Rs_addr_in = rs_a; Rs_data_in = rs_d;
        Rt_addr_in = rt_a; Rt_data_in = rt_d;
        Rd_addr_in = rd_a; Reg_dst_in = 1; Reg_w_in = 1;
    endtask

    // One falling edge (state update), then settle before sampling.
    task automatic step();
        @(negedge clk);
        #1;
        $display("[%0t] op=%b imm=%h -> result=%h rd=%0d regw=%b memw=%b zero=%b stall=%b",
                 $time, ALU_op_in, Imm_in, ALU_result_out, Rd_addr_out, Reg_w_out,
                 Mem_w_out, Zero_out, Stall_out);
    endtask

    initial begin
        int stall_edges, bubbles;
        logic saw_w;

        // Reset with live inputs: everything must read zero.
        rst = 1;
        rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        step();
        chk("rst_result", ALU_result_out, 32'd0);
        chk("rst_rd", Rd_addr_out, 5'd0);
        chk("rst_regw", Reg_w_out, 1'b0);
        chk("rst_zero", Zero_out, 1'b0);
        chk("rst_stall", Stall_out, 1'b0);
        rst = 0;

        // add $3 = $1 + $2
        rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        step();
        chk("add_result", ALU_result_out, 32'd12);
        chk("add_rd", Rd_addr_out, 5'd3);
        chk("add_regw", Reg_w_out, 1'b1);

        // sub $4 = $3 - $1 using EX/MEM forwarding (stale RF value 0 for $3)
        rtype(6'h22, 5'd3, 32'd0, 5'd1, 32'd5, 5'd4);
        step();
        chk("fwd_exmem_sub", ALU_result_out, 32'd7);
        chk("fwd_exmem_rd", Rd_addr_out, 5'd4);

        // Same pair with a nop between: MEM/WB forwarding
        rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        step();
        clear_in();
        step();
        chk("nop_regw", Reg_w_out, 1'b0);
        rtype(6'h22, 5'd3, 32'd0, 5'd1, 32'd5, 5'd4);
        MEMWB_Reg_w_in = 1; MEMWB_Rd_addr_in = 5'd3; MEMWB_data_in = 32'd12;
        step();
        chk("fwd_memwb_sub", ALU_result_out, 32'd7);

        // Both stages match: EX/MEM must win over the older MEM/WB value
        rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        step();
        rtype(6'h22, 5'd3, 32'd0, 5'd1, 32'd5, 5'd4);
        MEMWB_Reg_w_in = 1; MEMWB_Rd_addr_in = 5'd3; MEMWB_data_in = 32'd100;
        step();
        chk("fwd_priority", ALU_result_out, 32'd7);

        // Writes to $0 are never forwarded
        rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd0);
        step();
        chk("w0_result", ALU_result_out, 32'd12);
        rtype(6'h20, 5'd0, 32'd0, 5'd2, 32'd7, 5'd5);
        MEMWB_Reg_w_in = 1; MEMWB_Rd_addr_in = 5'd0; MEMWB_data_in = 32'd99;
        step();
        chk("no_fwd_r0", ALU_result_out, 32'd7);

        // slt signed
        rtype(6'h2A, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 5'd6);
        step();
        chk("slt_neg_lt_pos", ALU_result_out, 32'd1);
        rtype(6'h2A, 5'd1, 32'd1, 5'd2, 32'hFFFF_FFFF, 5'd6);
        step();
        chk("slt_pos_lt_neg", ALU_result_out, 32'd0);
        chk("slt_zero_flag", Zero_out, 1'b1);

        // and / or
        rtype(6'h24, 5'd1, 32'hF0F0_1234, 5'd2, 32'h0FF0_FF00, 5'd6);
        step();
        chk("and_result", ALU_result_out, 32'h00F0_1200);
        rtype(6'h25, 5'd1, 32'hF000_0001, 5'd2, 32'h0000_0F00, 5'd6);
        step();
        chk("or_result", ALU_result_out, 32'hF000_0F01);

        // ori zero-extends the immediate; destination is Rt
        clear_in();
        ALU_op_in = 2'b11; ALU_src_in = 1; Imm_in = 32'hFFFF_8000;
        Rs_addr_in = 5'd0; Rt_addr_in = 5'd6; Rd_addr_in = 5'd9; Reg_w_in = 1;
        step();
        chk("ori_result", ALU_result_out, 32'h0000_8000);
        chk("ori_rd", Rd_addr_out, 5'd6);

        // Add wraps modulo 2^32
        rtype(6'h20, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 5'd8);
        step();
        chk("add_wrap", ALU_result_out, 32'd0);
        chk("add_wrap_zero", Zero_out, 1'b1);

        // Unknown funct: result 0, controls still pass
        rtype(6'h27, 5'd1, 32'd3, 5'd2, 32'd5, 5'd10);
        step();
        chk("unk_result", ALU_result_out, 32'd0);
        chk("unk_regw", Reg_w_out, 1'b1);
        chk("unk_rd", Rd_addr_out, 5'd10);

        // sw after add $7: store data forwarded, address = base + offset
        rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd7);
        step();
        clear_in();
        ALU_op_in = 2'b00; ALU_src_in = 1; Imm_in = 32'd4;
        Rs_addr_in = 5'd8; Rs_data_in = 32'h100; Rt_addr_in = 5'd7; Rt_data_in = 32'd0;
        Mem_w_in = 1;
        step();
        chk("sw_addr", ALU_result_out, 32'h104);
        chk("sw_data", Rt_data_out, 32'd12);
        chk("sw_memw", Mem_w_out, 1'b1);
        chk("sw_regw", Reg_w_out, 1'b0);

        // Asynchronous reset mid-run, between edges
        rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        step();
        #1 rst = 1;
        #1;
        chk("async_rst_result", ALU_result_out, 32'd0);
        chk("async_rst_regw", Reg_w_out, 1'b0);
        chk("async_rst_rd", Rd_addr_out, 5'd0);
        rst = 0;

`ifdef EX_MULT_EN
        rtype(6'h18, 5'd1, 32'h0000_FFFF, 5'd2, 32'h0001_0001, 5'd9);
        #1;
        chk("mult_stall_initial", Stall_out, 1'b1);
        stall_edges = 0;
        bubbles = 0;
        for (int e = 0; e < 40 && Stall_out; e++) begin
            stall_edges++;
            step();
            if (Reg_w_out === 1'b0 && ALU_result_out === 32'd0) bubbles++;
        end
        chk("mult_stall_edges", stall_edges, 33);
        chk("mult_bubbles", bubbles, 33);
        step();
        chk("mult_product", ALU_result_out, 32'hFFFF_FFFF);
        chk("mult_rd", Rd_addr_out, 5'd9);
        chk("mult_regw", Reg_w_out, 1'b1);
        clear_in();

        // Reset at edge 10 of a multiply abandons it
        rtype(6'h18, 5'd1, 32'd3, 5'd2, 32'd4, 5'd9);
        repeat (10) step();
        chk("mult_busy_stall", Stall_out, 1'b1);
        #1 rst = 1;
        #1;
        clear_in();
        #1;
        chk("mult_rst_stall", Stall_out, 1'b0);
        chk("mult_rst_regw", Reg_w_out, 1'b0);
        rst = 0;
        rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        step();
        chk("post_rst_add", ALU_result_out, 32'd12);
        clear_in();
        saw_w = 1'b0;
        repeat (40) begin
            step();
            if (Reg_w_out) saw_w = 1'b1;
        end
        chk("mult_rst_no_wb", saw_w, 1'b0);
`else
        // Without the multiplier, funct 0x18 is just an unknown funct
        rtype(6'h18, 5'd1, 32'h0000_FFFF, 5'd2, 32'h0001_0001, 5'd9);
        #1;
        chk("nomult_stall", Stall_out, 1'b0);
        step();
        chk("nomult_result", ALU_result_out, 32'd0);
        chk("nomult_regw", Reg_w_out, 1'b1);
        clear_in();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
